// File: rtl/change_dispenser.sv
// ============================================================================
// Module   : change_dispenser
// Purpose  : Consumer side of the vending FSM. Queues one-cycle dispense and
//            coin-return pulses, drives the product motor and the nickel/dime
//            hopper solenoids one item at a time, confirms each coin with an
//            exit sensor, tracks hopper inventory, substitutes two nickels for
//            a dime when dimes run out, and flags jams/shortages.
// Ports    : clk, reset (async, active-high)
//            dispense, returnNickel, returnDime, returnTwoDimes : request pulses
//            n_seen, d_seen        : coin exit sensor pulses
//            load_n, load_d, load_val : hopper refill
//            clr_fault             : leave FAULT, clear ovf
//            vend_motor, eject_n, eject_d : actuator drives
//            inv_n, inv_d          : hopper inventory
//            busy, fault, ovf      : status
//            paid_out_cents        : cents paid out (CHANGE_AUDIT_EN only)
// Options  : `define CHANGE_AUDIT_EN to add the paid_out_cents audit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser #(
  parameter int VEND_CYC  = 4,
  parameter int EJECT_CYC = 8,
  parameter int TIMEOUT   = 64,
  parameter int INV_W     = 8,
  parameter int PEND_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dispense,
  input  logic             returnNickel,
  input  logic             returnDime,
  input  logic             returnTwoDimes,
  input  logic             n_seen,
  input  logic             d_seen,
  input  logic             load_n,
  input  logic             load_d,
  input  logic [INV_W-1:0] load_val,
  input  logic             clr_fault,
  output logic             vend_motor,
  output logic             eject_n,
  output logic             eject_d,
  output logic [INV_W-1:0] inv_n,
  output logic [INV_W-1:0] inv_d,
  output logic             busy,
  output logic             fault,
`ifdef CHANGE_AUDIT_EN
  output logic [15:0]      paid_out_cents,
`endif
  output logic             ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VEND  = 3'd1;
  localparam logic [2:0] S_SEL   = 3'd2;
  localparam logic [2:0] S_EJECT = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam int              CNT_W      = 16;
  localparam logic [CNT_W-1:0] VEND_LAST  = CNT_W'(VEND_CYC - 1);
  localparam logic [CNT_W-1:0] EJECT_LAST = CNT_W'(EJECT_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 1);

  // Pending sums are formed two bits wider so that +2 and saturation are exact.
  localparam int             PW2      = PEND_W + 2;
  localparam logic [PW2-1:0] PEND_MAX = PW2'((2 ** PEND_W) - 1);

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              sel_dime, sel_dime_nxt;
  logic [3:0]        pend_v;
  logic [PEND_W-1:0] pend_n, pend_d;
  logic              vend_done, subst, ack_n, ack_d;
  logic              any_pend, any_req;
  logic [PW2-1:0]    sum_n, sum_d;
  logic [4:0]        sum_v;

  assign any_pend = (pend_v != '0) || (pend_n != '0) || (pend_d != '0);
  assign any_req  = dispense || returnNickel || returnDime || returnTwoDimes;

  // State register; the shared cycle counter restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sel_dime <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
      sel_dime <= sel_dime_nxt;
    end
  end

  // Next-state logic plus the one-cycle bookkeeping events it decides.
  always_comb begin
    state_nxt    = state;
    sel_dime_nxt = sel_dime;
    vend_done    = 1'b0;
    subst        = 1'b0;
    ack_n        = 1'b0;
    ack_d        = 1'b0;
    case (state)
      // Looking at live requests too lets a pulse reach the actuator at t+2.
      S_IDLE: if (any_pend || any_req) state_nxt = S_SEL;
      S_SEL: begin
        if (pend_v != '0) begin
          state_nxt = S_VEND;
        end else if (pend_d != '0) begin
          if (inv_d != '0) begin
            state_nxt    = S_EJECT;
            sel_dime_nxt = 1'b1;
          end else begin
            subst = 1'b1;           // owe two nickels instead, re-decide next cycle
          end
        end else if (pend_n != '0) begin
          if (inv_n != '0) begin
            state_nxt    = S_EJECT;
            sel_dime_nxt = 1'b0;
          end else begin
            state_nxt = S_FAULT;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_VEND: if (cnt == VEND_LAST) begin
        vend_done = 1'b1;
        state_nxt = S_SEL;
      end
      S_EJECT: if (cnt == EJECT_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        // A pulse from the wrong hopper means a mis-feed; it outranks the right one.
        if (sel_dime ? n_seen : d_seen) begin
          state_nxt = S_FAULT;
        end else if (sel_dime ? d_seen : n_seen) begin
          ack_d     = sel_dime;
          ack_n     = !sel_dime;
          state_nxt = S_SEL;
        end else if (cnt == WAIT_LAST) begin
          state_nxt = S_FAULT;
        end
      end
      S_FAULT: if (clr_fault) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the state only, so reset removes every drive immediately.
  always_comb begin
    vend_motor = (state == S_VEND);
    eject_n    = (state == S_EJECT) && !sel_dime;
    eject_d    = (state == S_EJECT) && sel_dime;
    fault      = (state == S_FAULT);
    busy       = (state != S_IDLE) || any_pend;
  end

  // Capture and consumption net out in one sum per counter.
  always_comb begin
    sum_n = PW2'(pend_n) + PW2'(returnNickel) + (subst ? PW2'(2) : PW2'(0)) - PW2'(ack_n);
    sum_d = PW2'(pend_d) + PW2'(returnDime) + (returnTwoDimes ? PW2'(2) : PW2'(0))
            - PW2'(subst) - PW2'(ack_d);
    sum_v = {1'b0, pend_v} + {4'd0, dispense} - {4'd0, vend_done};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v <= '0;
      pend_n <= '0;
      pend_d <= '0;
      ovf    <= 1'b0;
      inv_n  <= '0;
      inv_d  <= '0;
    end else begin
      pend_n <= (sum_n > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : sum_n[PEND_W-1:0];
      pend_d <= (sum_d > PEND_MAX) ? PEND_MAX[PEND_W-1:0] : sum_d[PEND_W-1:0];
      pend_v <= (sum_v > 5'd15) ? 4'd15 : sum_v[3:0];
      // A fresh saturation wins over a simultaneous clear.
      if ((sum_n > PEND_MAX) || (sum_d > PEND_MAX)) ovf <= 1'b1;
      else if (clr_fault)                           ovf <= 1'b0;
      // A refill overrides a same-cycle coin decrement.
      if (load_n)     inv_n <= load_val;
      else if (ack_n) inv_n <= inv_n - 1'b1;
      if (load_d)     inv_d <= load_val;
      else if (ack_d) inv_d <= inv_d - 1'b1;
    end
  end

`ifdef CHANGE_AUDIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) paid_out_cents <= '0;
    else       paid_out_cents <= paid_out_cents + (ack_d ? 16'd10 : (ack_n ? 16'd5 : 16'd0));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed, self-checking bench for change_dispenser. Inputs change
//            on the falling clock edge; outputs are sampled there too.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dispense = 1'b0, returnNickel = 1'b0, returnDime = 1'b0, returnTwoDimes = 1'b0;
  logic       n_seen = 1'b0, d_seen = 1'b0;
  logic       load_n = 1'b0, load_d = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       clr_fault = 1'b0;
  logic       vend_motor, eject_n, eject_d, busy, fault, ovf;
  logic [7:0] inv_n, inv_d;
`ifdef CHANGE_AUDIT_EN
  logic [15:0] paid_out_cents;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int len;

  change_dispenser dut (
    .clk(clk), .reset(reset),
    .dispense(dispense), .returnNickel(returnNickel),
    .returnDime(returnDime), .returnTwoDimes(returnTwoDimes),
    .n_seen(n_seen), .d_seen(d_seen),
    .load_n(load_n), .load_d(load_d), .load_val(load_val),
    .clr_fault(clr_fault),
    .vend_motor(vend_motor), .eject_n(eject_n), .eject_d(eject_d),
    .inv_n(inv_n), .inv_d(inv_d),
    .busy(busy), .fault(fault),
`ifdef CHANGE_AUDIT_EN
    .paid_out_cents(paid_out_cents),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic drive_of(input int which);
    case (which)
      0:       return vend_motor;
      1:       return eject_n;
      default: return eject_d;
    endcase
  endfunction

  // Waits (bounded) for a drive to rise, then returns how many samples it stayed high.
  task automatic measure(input string tag, input int which, output int n);
    int guard = 0;
    n = 0;
    while (drive_of(which) !== 1'b1 && guard < 300) begin tick(); guard++; end
    if (guard >= 300) begin
      check({tag, "_start_timeout"}, 32'd0, 32'd1);
    end else begin
      while (drive_of(which) === 1'b1 && n < 300) begin tick(); n++; end
    end
  endtask

  task automatic sense(input bit dime);
    if (dime) d_seen = 1'b1; else n_seen = 1'b1;
    tick();
    d_seen = 1'b0;
    n_seen = 1'b0;
  endtask

  task automatic load(input bit ln, input bit ld, input logic [7:0] v);
    load_n = ln; load_d = ld; load_val = v;
    tick();
    load_n = 1'b0; load_d = 1'b0;
  endtask

  // One coin: burst length must equal the eject time, then acknowledge it.
  task automatic serve(input string tag, input bit dime);
    int l;
    measure(tag, dime ? 2 : 1, l);
    check({tag, "_eject_len"}, l, 8);
    sense(dime);
  endtask

  initial begin
    // ---- reset state ----
    tick(); tick();
    check("rst_vend", vend_motor, 0);
    check("rst_ej_n", eject_n, 0);
    check("rst_ej_d", eject_d, 0);
    check("rst_inv_n", inv_n, 0);
    check("rst_inv_d", inv_d, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();

    // ---- T1: two dimes ----
    load(1, 1, 8'd5);
    check("t1_inv_n_load", inv_n, 5);
    check("t1_inv_d_load", inv_d, 5);
    returnTwoDimes = 1'b1; tick(); returnTwoDimes = 1'b0;
    check("t1_lat_t1", eject_d, 0);
    tick();
    check("t1_lat_t2", eject_d, 1);
    serve("t1_dime1", 1);
    serve("t1_dime2", 1);
    repeat (3) tick();
    check("t1_inv_d", inv_d, 3);
    check("t1_busy", busy, 0);
    check("t1_fault", fault, 0);

    // ---- T2: vend then nickel ----
    dispense = 1'b1; returnNickel = 1'b1; tick(); dispense = 1'b0; returnNickel = 1'b0;
    tick();
    check("t2_vend_first", vend_motor, 1);
    check("t2_no_eject_during_vend", eject_n, 0);
    measure("t2_vend", 0, len);
    check("t2_vend_len", len, 4);
    serve("t2_nickel", 0);
    repeat (3) tick();
    check("t2_inv_n", inv_n, 4);
    check("t2_busy", busy, 0);

    // ---- T3: dime substituted by two nickels ----
    load(0, 1, 8'd0);
    check("t3_inv_d_zero", inv_d, 0);
    returnDime = 1'b1; tick(); returnDime = 1'b0;
    serve("t3_nick1", 0);
    serve("t3_nick2", 0);
    repeat (3) tick();
    check("t3_inv_n", inv_n, 2);
    check("t3_inv_d", inv_d, 0);
    check("t3_fault", fault, 0);
    check("t3_busy", busy, 0);

    // ---- T4: sensor timeout, requests in FAULT, recovery ----
    load(0, 1, 8'd5);
    returnDime = 1'b1; tick(); returnDime = 1'b0;
    measure("t4_dime", 2, len);
    check("t4_eject_len", len, 8);
    repeat (63) tick();
    check("t4_no_fault_at_63", fault, 0);
    tick();
    check("t4_fault_at_64", fault, 1);
    check("t4_ej_d_off", eject_d, 0);
    check("t4_ej_n_off", eject_n, 0);
    check("t4_vend_off", vend_motor, 0);
    check("t4_inv_d_kept", inv_d, 5);
    returnNickel = 1'b1; tick(); returnNickel = 1'b0;
    tick();
    check("t4_still_fault", fault, 1);
    check("t4_busy_fault", busy, 1);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t4_cleared", fault, 0);
    serve("t4_retry_dime", 1);
    serve("t4_nickel", 0);
    repeat (3) tick();
    check("t4_inv_d", inv_d, 4);
    check("t4_inv_n", inv_n, 1);
    check("t4_busy_end", busy, 0);

    // ---- T5: wrong sensor, then pending-nickel saturation ----
    returnDime = 1'b1; tick(); returnDime = 1'b0;
    measure("t5_dime", 2, len);
    sense(0);
    check("t5_wrong_coin_fault", fault, 1);
    check("t5_inv_n_unchanged", inv_n, 1);
    check("t5_inv_d_unchanged", inv_d, 4);
    for (int i = 0; i < 15; i++) begin
      returnNickel = 1'b1; tick(); returnNickel = 1'b0; tick();
    end
    check("t5_ovf_at_15", ovf, 0);
    returnNickel = 1'b1; tick(); returnNickel = 1'b0; tick();
    check("t5_ovf_at_16", ovf, 1);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t5_ovf_cleared", ovf, 0);
    check("t5_fault_cleared", fault, 0);

    // ---- T6: asynchronous reset during EJECT ----
    begin
      int guard = 0;
      while (eject_d !== 1'b1 && guard < 50) begin tick(); guard++; end
      check("t6_reach_eject", eject_d, 1);
    end
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("t6_ej_d_async", eject_d, 0);
    check("t6_inv_n", inv_n, 0);
    check("t6_inv_d", inv_d, 0);
    check("t6_busy", busy, 0);
    check("t6_fault", fault, 0);
`ifdef CHANGE_AUDIT_EN
    check("t6_paid_rst", paid_out_cents, 0);
`endif
    tick(); reset = 1'b0;
    repeat (3) tick();
    check("t6_pend_cleared", busy, 0);

    // ---- one dime + one nickel after reset ----
    load(1, 1, 8'd5);
    returnDime = 1'b1; returnNickel = 1'b1; tick(); returnDime = 1'b0; returnNickel = 1'b0;
    serve("t6_dime", 1);
    serve("t6_nickel", 0);
    repeat (3) tick();
    check("t6_inv_d_end", inv_d, 4);
    check("t6_inv_n_end", inv_n, 4);
`ifdef CHANGE_AUDIT_EN
    check("t6_paid_15", paid_out_cents, 15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
